pwm_decoder: RTL and testbench
==============================

# pwm_decoder

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive-side counterpart of the team's 8-bit PWM generator, used for loopback checking and for capturing external PWM inputs. The input is synchronized and edge-detected, and one measurement is published per full PWM period. Constant-level inputs are flagged through a saturation timeout.

## Interface
- CNT_W, 16, width of the high-time/period counters and outputs (must be ≥ 9 to hold a 256-cycle period)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- pwm_in  input  1  asynchronous PWM input
- high_time  output  CNT_W  cycles the input was high in the last complete period
- period  output  CNT_W  cycles from one rising edge to the next
- meas_valid  output  1  one-cycle pulse when high_time/period update
- timeout  output  1  one-cycle pulse when no edge arrives before counter saturation
- stuck_level  output  1  level of pwm_in latched at the last timeout

## Operation
- Synchronizer: two flops s1, s2 followed by history flop s3, all reset to 0.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
- FSM states: IDLE, ARMED, HIGH, LOW. Reset state is IDLE.
  - IDLE: wait for s2 == 0, then go to ARMED. This rejects a line that is already high at reset release.
  - ARMED: on rise, set cnt_hi <= 1 and cnt_per <= 1, go to HIGH.
  - HIGH: cnt_hi and cnt_per increment each cycle. On fall, go to LOW; cnt_hi does not increment in the fall cycle, cnt_per does.
  - LOW: cnt_per increments. On rise, latch high_time <= cnt_hi and period <= cnt_per, pulse meas_valid, reload both counters to 1, go to HIGH.
- No measurement is produced for the first period after reset or after a timeout.
- Saturation: when cnt_per equals all-ones in HIGH or LOW and no edge is present that cycle:
  - pulse timeout
  - stuck_level <= s2
  - go to IDLE
  - high_time and period hold their previous values.
- Edge and saturation in the same cycle: the edge wins.
- Outputs high_time and period hold their values between updates.
- Reset values: every output is 0, all counters are 0, the synchronizer flops are 0, and the state is IDLE.
- rst low mid-measurement aborts it at the next clk edge. There is no partial result and no timeout pulse.

## Timing
- A change on pwm_in sampled at edge k appears in s2 at edge k+1. The corresponding rise/fall is decoded during the cycle after edge k+1.
- meas_valid is registered: it asserts at edge k+2 relative to the sampling of the second rising edge, and lasts exactly 1 cycle.
- Because the edge-detect delay is identical for both edges, measured values equal the true input cycle counts for clk-synchronous inputs.
- Generator loopback:
  - duty D with 1 ≤ D ≤ 255 gives high_time = D and period = 256.
  - D = 0 gives a constant-low input and a timeout with stuck_level = 0.
- Minimum measurable pulse: 1 cycle high or 1 cycle low.

## Structure
- Package pwm_pkg holds:
  - the state typedef (IDLE, ARMED, HIGH, LOW)
  - the default counter width constant
  - PWM_GEN_PERIOD = 256, shared with the generator
- Sub-module pwm_sync_edge: 2-flop synchronizer, history flop, and rise/fall outputs, with synchronous active-low reset. It is instantiated once.
- The FSM, counters and output registers live in pwm_decoder.

## Test plan
- Loopback with the 8-bit generator at duty 64: meas_valid once every 256 cycles with high_time = 64 and period = 256. The first measurement appears only after the second rising edge.
- Loopback with duty 255, then duty 1: high_time = 255 and 1 respectively, period = 256 in both cases.
- pwm_in held high through reset release, then the 100-high/50-low pattern from the next scenario: no meas_valid until the line has gone low once. After that, high_time = 100 and period = 150.
- Constant low for more than 2^CNT_W cycles after an armed rise, with CNT_W = 9: timeout pulses once, stuck_level = 0, state returns to IDLE, and high_time/period are unchanged.
- Drive rst low mid-HIGH, hold it for 3 cycles, then release: all outputs are 0 and there is no meas_valid or timeout. Measurement resumes correctly after the next low-then-rise sequence.
- Irregular sequence of 3 high / 1 low / 1 high / 5 low: the second result is high_time = 1, period = 6. This checks 1-cycle pulses and the back-to-back latch-and-reload behaviour.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM receive path.
//   pwm_state_t    : decoder FSM state encoding
//   CNT_W_DEFAULT  : default width of the high-time/period counters
//   PWM_GEN_PERIOD : period of the team's 8-bit PWM generator, in clk cycles
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } pwm_state_t;

    localparam int CNT_W_DEFAULT  = 16;
    localparam int PWM_GEN_PERIOD = 256;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge
// Two-flop synchronizer plus history flop for an asynchronous PWM input.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-low reset
//   pwm_in : asynchronous PWM input
//   level  : synchronized input level (s2)
//   rise   : s2 & ~s3
//   fall   : ~s2 & s3
//   primed : high once s2 holds a real sample of pwm_in rather than its
//            reset value
module pwm_sync_edge
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic primed
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] warm;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            warm <= 2'b00;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            s3   <= s2;
            warm <= {warm[0], 1'b1};
        end
    end

    assign level  = s2;
    assign rise   = s2 & ~s3;
    assign fall   = ~s2 & s3;
    // s2 comes out of reset as 0 regardless of the line, so a line that is
    // high through reset release must not be mistaken for a low.
    assign primed = warm[1];

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder
// Measures high time and period (in clk cycles) of an incoming PWM signal.
// One result is published per full period, rising edge to rising edge.
// A line that stops toggling is reported through a saturation timeout.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-low reset
//   pwm_in      : asynchronous PWM input
//   high_time   : cycles high in the last complete period
//   period      : cycles between the last two rising edges
//   meas_valid  : one-cycle pulse when high_time/period update
//   timeout     : one-cycle pulse when the period counter saturates
//   stuck_level : synchronized input level captured at the last timeout
//
// state | meaning
// IDLE  | wait for a primed low level before accepting a rising edge
// ARMED | line seen low, waiting for the first rising edge
// HIGH  | inside the high phase, both counters running
// LOW   | inside the low phase, period counter running
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic level;
    logic rise;
    logic fall;
    logic primed;

    pwm_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .primed (primed)
    );

    pwm_state_t       state;
    pwm_state_t       state_nxt;
    logic [CNT_W-1:0] cnt_hi;
    logic [CNT_W-1:0] cnt_per;
    logic [CNT_W-1:0] cnt_hi_nxt;
    logic [CNT_W-1:0] cnt_per_nxt;
    logic [CNT_W-1:0] high_time_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             meas_nxt;
    logic             timeout_nxt;
    logic             stuck_nxt;
    logic             sat;
    logic [CNT_W-1:0] per_inc;

    assign sat     = (cnt_per == CNT_MAX);
    // A fall landing exactly on saturation still wins over the timeout; the
    // counter then holds at all-ones so the timeout fires on the next quiet
    // cycle instead of wrapping.
    assign per_inc = sat ? cnt_per : cnt_per + CNT_ONE;

    always_comb begin
        state_nxt     = state;
        cnt_hi_nxt    = cnt_hi;
        cnt_per_nxt   = cnt_per;
        high_time_nxt = high_time;
        period_nxt    = period;
        meas_nxt      = 1'b0;
        timeout_nxt   = 1'b0;
        stuck_nxt     = stuck_level;

        case (state)
            IDLE: begin
                if (primed && !level) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    cnt_hi_nxt  = CNT_ONE;
                    cnt_per_nxt = CNT_ONE;
                    state_nxt   = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    cnt_per_nxt = per_inc;
                    state_nxt   = LOW;
                end else if (sat) begin
                    timeout_nxt = 1'b1;
                    stuck_nxt   = level;
                    state_nxt   = IDLE;
                end else begin
                    cnt_hi_nxt  = cnt_hi + CNT_ONE;
                    cnt_per_nxt = per_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    high_time_nxt = cnt_hi;
                    period_nxt    = cnt_per;
                    meas_nxt      = 1'b1;
                    cnt_hi_nxt    = CNT_ONE;
                    cnt_per_nxt   = CNT_ONE;
                    state_nxt     = HIGH;
                end else if (sat) begin
                    timeout_nxt = 1'b1;
                    stuck_nxt   = level;
                    state_nxt   = IDLE;
                end else begin
                    cnt_per_nxt = per_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt_hi      <= '0;
            cnt_per     <= '0;
            high_time   <= '0;
            period      <= '0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt_hi      <= cnt_hi_nxt;
            cnt_per     <= cnt_per_nxt;
            high_time   <= high_time_nxt;
            period      <= period_nxt;
            meas_valid  <= meas_nxt;
            timeout     <= timeout_nxt;
            stuck_level <= stuck_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
// Self-checking bench for pwm_decoder (CNT_W = 9). Stimulus is a per-cycle
// level sequence; expected results are derived from the sequence itself:
// every rising edge after an armed rise yields one measurement three cycles
// later, and 2^CNT_W-1 cycles without a rise after the last rise yields a
// timeout.
module tb_pwm_decoder;

    localparam int CW   = 9;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] high_time;
    logic [CW-1:0] period;
    logic          meas_valid;
    logic          timeout;
    logic          stuck_level;

    pwm_decoder #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .high_time   (high_time),
        .period      (period),
        .meas_valid  (meas_valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int hi; int per; } meas_t;
    typedef struct { int cyc; int lvl; int hi; int per; } to_t;

    meas_t obs_m[$];
    meas_t exp_m[$];
    to_t   obs_t[$];
    to_t   exp_t[$];
    bit    stim[$];

    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        meas_t m;
        to_t   t;
        if (meas_valid === 1'b1) begin
            m.cyc = cyc; m.hi = int'(high_time); m.per = int'(period);
            obs_m.push_back(m);
        end
        if (timeout === 1'b1) begin
            t.cyc = cyc; t.lvl = int'(stuck_level);
            t.hi = int'(high_time); t.per = int'(period);
            obs_t.push_back(t);
        end
    end

    task automatic add_seg(input bit lvl, input int n);
        repeat (n) stim.push_back(lvl);
    endtask

    // 8-bit generator: high while the phase counter is below the duty value.
    task automatic add_gen(input int duty, input int periods);
        for (int p = 0; p < periods; p++)
            for (int n = 0; n < 256; n++)
                stim.push_back(n < duty);
    endtask

    task automatic do_reset(input bit lvl);
        @(posedge clk); #1;
        rst    = 1'b0;
        pwm_in = lvl;
        repeat (3) @(posedge clk);
    endtask

    // Releases reset together with the first stimulus sample; base is the
    // cycle count at which sample 0 was driven.
    task automatic apply(output int base);
        base = 0;
        obs_m.delete();
        obs_t.delete();
        for (int i = 0; i < stim.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                base = cyc;
                rst  = 1'b1;
            end
            pwm_in = stim[i];
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic build_expect(input int base);
        int    st;
        int    r;
        int    hi;
        int    lhi;
        int    lper;
        bit    rise;
        meas_t m;
        to_t   t;
        st = 0; r = 0; hi = 0; lhi = 0; lper = 0;
        exp_m.delete();
        exp_t.delete();
        for (int i = 0; i < stim.size(); i++) begin
            rise = (i > 0) && stim[i] && !stim[i-1];
            if (st == 0) begin
                if (!stim[i]) st = 1;
            end else if (st == 1) begin
                if (rise) begin st = 2; r = i; hi = 1; end
            end else begin
                if (rise) begin
                    m.cyc = base + i + 3; m.hi = hi; m.per = i - r;
                    exp_m.push_back(m);
                    lhi = hi; lper = i - r;
                    r = i; hi = 1;
                end else if (i - r == MAXC) begin
                    t.cyc = base + i + 3; t.lvl = int'(stim[i]);
                    t.hi = lhi; t.per = lper;
                    exp_t.push_back(t);
                    st = 0;
                end else if (stim[i]) begin
                    hi++;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        #1;
        n_tests++;
        if (high_time !== '0 || period !== '0 || meas_valid !== 1'b0 ||
            timeout !== 1'b0 || stuck_level !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ht=%0d per=%0d mv=%b to=%b sl=%b expected all 0",
                     high_time, period, meas_valid, timeout, stuck_level);
        end
    endtask

    task automatic test_loopback_64();
        int base;
        stim.delete();
        add_gen(64, 5);
        do_reset(1'b0);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != exp_m.size() || obs_t.size() != 0) begin
            n_fail++;
            $display("FAIL loop64_count: got meas=%0d to=%0d expected meas=%0d to=0",
                     obs_m.size(), obs_t.size(), exp_m.size());
        end
        for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
            n_tests++;
            if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != exp_m[k].hi || obs_m[k].per != exp_m[k].per) begin
                n_fail++;
                $display("FAIL loop64_meas[%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=%0d per=%0d",
                         k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc, exp_m[k].hi, exp_m[k].per);
            end
        end
        n_tests++;
        if (obs_m.size() == 0 || obs_m[0].cyc != base + 512 + 3 || obs_m[0].hi != 64 || obs_m[0].per != 256) begin
            n_fail++;
            $display("FAIL loop64_first: got n=%0d expected first at cyc=%0d hi=64 per=256",
                     obs_m.size(), base + 515);
        end
        n_tests++;
        if (high_time !== CW'(64) || period !== CW'(256)) begin
            n_fail++;
            $display("FAIL loop64_hold: got ht=%0d per=%0d expected 64/256", high_time, period);
        end
    endtask

    task automatic test_loopback_255_1();
        int base;
        int last;
        stim.delete();
        add_gen(255, 3);
        add_gen(1, 3);
        add_seg(1'b1, 1);
        do_reset(1'b0);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != exp_m.size() || obs_t.size() != 0) begin
            n_fail++;
            $display("FAIL loop255_1_count: got meas=%0d to=%0d expected meas=%0d to=0",
                     obs_m.size(), obs_t.size(), exp_m.size());
        end
        for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
            n_tests++;
            if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != exp_m[k].hi || obs_m[k].per != exp_m[k].per) begin
                n_fail++;
                $display("FAIL loop255_1_meas[%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=%0d per=%0d",
                         k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc, exp_m[k].hi, exp_m[k].per);
            end
        end
        last = obs_m.size() - 1;
        n_tests++;
        if (last < 1 || obs_m[0].hi != 255 || obs_m[0].per != 256 || obs_m[last].hi != 1 || obs_m[last].per != 256) begin
            n_fail++;
            $display("FAIL loop255_1_values: got n=%0d first hi=%0d last hi=%0d expected 255 then 1, per 256",
                     obs_m.size(), (last >= 0) ? obs_m[0].hi : -1, (last >= 0) ? obs_m[last].hi : -1);
        end
    endtask

    task automatic test_loopback_random();
        int base;
        int duty;
        duty = int'($urandom_range(2, 254));
        stim.delete();
        add_gen(duty, 4);
        add_seg(1'b1, 1);
        do_reset(1'b0);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != exp_m.size() || obs_t.size() != 0) begin
            n_fail++;
            $display("FAIL loop_rand_count: duty=%0d got meas=%0d to=%0d expected meas=%0d to=0",
                     duty, obs_m.size(), obs_t.size(), exp_m.size());
        end
        for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
            n_tests++;
            if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != duty || obs_m[k].per != 256) begin
                n_fail++;
                $display("FAIL loop_rand_meas[%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=%0d per=256",
                         k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc, duty);
            end
        end
    endtask

    task automatic test_high_at_reset();
        int base;
        stim.delete();
        add_seg(1'b1, 20);
        add_seg(1'b0, 50);
        for (int p = 0; p < 3; p++) begin
            add_seg(1'b1, 100);
            add_seg(1'b0, 50);
        end
        add_seg(1'b1, 5);
        do_reset(1'b1);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != exp_m.size() || obs_t.size() != 0) begin
            n_fail++;
            $display("FAIL high_rst_count: got meas=%0d to=%0d expected meas=%0d to=0",
                     obs_m.size(), obs_t.size(), exp_m.size());
        end
        for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
            n_tests++;
            if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != exp_m[k].hi || obs_m[k].per != exp_m[k].per) begin
                n_fail++;
                $display("FAIL high_rst_meas[%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=%0d per=%0d",
                         k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc, exp_m[k].hi, exp_m[k].per);
            end
        end
        n_tests++;
        if (obs_m.size() == 0 || obs_m[0].cyc != base + 220 + 3 || obs_m[0].hi != 100 || obs_m[0].per != 150) begin
            n_fail++;
            $display("FAIL high_rst_first: got n=%0d expected first at cyc=%0d hi=100 per=150",
                     obs_m.size(), base + 223);
        end
    endtask

    task automatic test_timeout();
        int base;
        stim.delete();
        add_seg(1'b0, 8);
        for (int p = 0; p < 2; p++) begin
            add_seg(1'b1, 30);
            add_seg(1'b0, 20);
        end
        add_seg(1'b1, 30);
        add_seg(1'b0, 600);
        for (int p = 0; p < 2; p++) begin
            add_seg(1'b1, 10);
            add_seg(1'b0, 10);
        end
        add_seg(1'b1, 605);
        add_seg(1'b0, 10);
        do_reset(1'b0);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != exp_m.size() || obs_t.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL timeout_count: got meas=%0d to=%0d expected meas=%0d to=%0d",
                     obs_m.size(), obs_t.size(), exp_m.size(), exp_t.size());
        end
        for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
            n_tests++;
            if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != exp_m[k].hi || obs_m[k].per != exp_m[k].per) begin
                n_fail++;
                $display("FAIL timeout_meas[%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=%0d per=%0d",
                         k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc, exp_m[k].hi, exp_m[k].per);
            end
        end
        for (int k = 0; k < exp_t.size() && k < obs_t.size(); k++) begin
            n_tests++;
            if (obs_t[k].cyc != exp_t[k].cyc || obs_t[k].lvl != exp_t[k].lvl ||
                obs_t[k].hi != exp_t[k].hi || obs_t[k].per != exp_t[k].per) begin
                n_fail++;
                $display("FAIL timeout_pulse[%0d]: got cyc=%0d lvl=%0d ht=%0d per=%0d expected cyc=%0d lvl=%0d ht=%0d per=%0d",
                         k, obs_t[k].cyc, obs_t[k].lvl, obs_t[k].hi, obs_t[k].per,
                         exp_t[k].cyc, exp_t[k].lvl, exp_t[k].hi, exp_t[k].per);
            end
        end
        n_tests++;
        if (obs_t.size() != 2 || obs_t[0].lvl != 0 || obs_t[0].hi != 30 || obs_t[0].per != 50 || obs_t[1].lvl != 1) begin
            n_fail++;
            $display("FAIL timeout_levels: got n=%0d expected 2 pulses, low stuck with 30/50 held, then high stuck",
                     obs_t.size());
        end
    endtask

    task automatic test_reset_mid_high();
        int base;
        stim.delete();
        add_seg(1'b0, 8);
        for (int p = 0; p < 2; p++) begin
            add_seg(1'b1, 30);
            add_seg(1'b0, 20);
        end
        add_seg(1'b1, 10);
        do_reset(1'b0);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != exp_m.size()) begin
            n_fail++;
            $display("FAIL rst_mid_pre_count: got %0d expected %0d", obs_m.size(), exp_m.size());
        end
        // Abort while the decoder sits in HIGH.
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        obs_m.delete();
        obs_t.delete();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (high_time !== '0 || period !== '0 || meas_valid !== 1'b0 ||
            timeout !== 1'b0 || stuck_level !== 1'b0 || obs_m.size() != 0 || obs_t.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got ht=%0d per=%0d mv=%b to=%b sl=%b pulses=%0d expected all 0",
                     high_time, period, meas_valid, timeout, stuck_level, obs_m.size() + obs_t.size());
        end
        stim.delete();
        add_seg(1'b0, 8);
        for (int p = 0; p < 2; p++) begin
            add_seg(1'b1, 15);
            add_seg(1'b0, 10);
        end
        add_seg(1'b1, 2);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != exp_m.size() || obs_t.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_post_count: got meas=%0d to=%0d expected meas=%0d to=0",
                     obs_m.size(), obs_t.size(), exp_m.size());
        end
        for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
            n_tests++;
            if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != 15 || obs_m[k].per != 25) begin
                n_fail++;
                $display("FAIL rst_mid_post_meas[%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=15 per=25",
                         k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc);
            end
        end
    endtask

    task automatic test_irregular();
        int base;
        stim.delete();
        add_seg(1'b0, 8);
        add_seg(1'b1, 3);
        add_seg(1'b0, 1);
        add_seg(1'b1, 1);
        add_seg(1'b0, 5);
        add_seg(1'b1, 1);
        add_seg(1'b0, 5);
        do_reset(1'b0);
        apply(base);
        build_expect(base);
        n_tests++;
        if (obs_m.size() != 2 || exp_m.size() != 2) begin
            n_fail++;
            $display("FAIL irregular_count: got %0d expected 2", obs_m.size());
        end
        for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
            n_tests++;
            if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != exp_m[k].hi || obs_m[k].per != exp_m[k].per) begin
                n_fail++;
                $display("FAIL irregular_meas[%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=%0d per=%0d",
                         k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc, exp_m[k].hi, exp_m[k].per);
            end
        end
        n_tests++;
        if (obs_m.size() < 2 || obs_m[1].hi != 1 || obs_m[1].per != 6) begin
            n_fail++;
            $display("FAIL irregular_second: got n=%0d expected second hi=1 per=6", obs_m.size());
        end
    endtask

    task automatic test_random_segments();
        int base;
        bit lvl;
        for (int run = 0; run < 3; run++) begin
            stim.delete();
            add_seg(1'b0, 10);
            lvl = 1'b1;
            for (int s = 0; s < 24; s++) begin
                add_seg(lvl, int'($urandom_range(1, 40)));
                lvl = ~lvl;
            end
            add_seg(1'b0, 5);
            add_seg(1'b1, 3);
            do_reset(1'b0);
            apply(base);
            build_expect(base);
            n_tests++;
            if (obs_m.size() != exp_m.size() || obs_t.size() != 0) begin
                n_fail++;
                $display("FAIL random_count[%0d]: got meas=%0d to=%0d expected meas=%0d to=0",
                         run, obs_m.size(), obs_t.size(), exp_m.size());
            end
            for (int k = 0; k < exp_m.size() && k < obs_m.size(); k++) begin
                n_tests++;
                if (obs_m[k].cyc != exp_m[k].cyc || obs_m[k].hi != exp_m[k].hi || obs_m[k].per != exp_m[k].per) begin
                    n_fail++;
                    $display("FAIL random_meas[%0d.%0d]: got cyc=%0d hi=%0d per=%0d expected cyc=%0d hi=%0d per=%0d",
                             run, k, obs_m[k].cyc, obs_m[k].hi, obs_m[k].per, exp_m[k].cyc, exp_m[k].hi, exp_m[k].per);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        pwm_in = 1'b0;
        test_reset();
        test_loopback_64();
        test_loopback_255_1();
        test_loopback_random();
        test_high_at_reset();
        test_timeout();
        test_reset_mid_high();
        test_irregular();
        test_random_segments();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
